front_panel_scanner: RTL and testbench

Scans the Altair front-panel switch/pushbutton matrix wired to the ULX3S GPIO header. It is the input counterpart of the address/data LED drive. Each cycle of the scan pulls one row line low, samples the active-low column lines after a settle time, debounces every key with a saturating integrator, and reports clean key state plus one-cycle press/release pulses. The top level turns `row_drive` into open-drain pins (`1` = drive 0, `0` = high-Z). It routes `keys`/`key_press` to the altair machine's sense switches and the examine/deposit/step inputs.

---
 rtl/front_panel_scanner.sv | 140 ++++++++++++++
 tb/tb_front_panel_scanner.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/front_panel_scanner.sv
// Front-panel key matrix scanner: one-hot active-low row drive, synchronized
// column sampling, per-key saturating debounce with press/release pulses.
module front_panel_scanner #(
    parameter int ROWS     = 4,
    parameter int COLS     = 8,
    parameter int SETTLE   = 250,
    parameter int DEBOUNCE = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [COLS-1:0]      col_n,
    output logic [ROWS-1:0]      row_drive,
    output logic [ROWS*COLS-1:0] keys,
    output logic [ROWS*COLS-1:0] key_press,
    output logic [ROWS*COLS-1:0] key_release,
    output logic                 scan_done
);

    localparam int NK = ROWS * COLS;
    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam int TW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

    typedef enum logic [0:0] {
        ST_IDLE,
        ST_SCAN
    } state_t;

    state_t              state_q, state_d;
    logic [RW-1:0]       r_q, r_d;
    logic [TW-1:0]       t_q, t_d;
    logic [ROWS-1:0]     row_drive_q, row_drive_d;
    logic                scan_done_q, scan_done_d;
    logic [COLS-1:0]     sync1_q, sync1_d;
    logic [COLS-1:0]     sync2_q, sync2_d;
    logic [COLS-1:0]     col_q, col_d;
    logic [NK-1:0][CW-1:0] cnt_q, cnt_d;
    logic [NK-1:0]       keys_q, keys_d;
    logic [NK-1:0]       key_press_q, key_press_d;
    logic [NK-1:0]       key_release_q, key_release_d;
    logic                sample;
    logic [CW-1:0]       cnt_new;

    always_comb begin
        state_d       = state_q;
        r_d           = r_q;
        t_d           = t_q;
        cnt_d         = cnt_q;
        keys_d        = keys_q;
        key_press_d   = '0;
        key_release_d = '0;
        cnt_new       = '0;
        sync1_d       = col_n;
        sync2_d       = sync1_q;
        col_d         = ~sync2_q;
        sample        = (state_q == ST_SCAN) && (t_q == TW'(SETTLE - 1));

        // Idle lasts one cycle after reset so row 0 is driven with t = 0.
        case (state_q)
            ST_IDLE: begin
                state_d = ST_SCAN;
                r_d     = '0;
                t_d     = '0;
            end
            ST_SCAN: begin
                if (sample) begin
                    t_d = '0;
                    r_d = (r_q == RW'(ROWS - 1)) ? '0 : r_q + RW'(1);
                end else begin
                    t_d = t_q + TW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        for (int unsigned rr = 0; rr < ROWS; rr++) begin
            for (int unsigned c = 0; c < COLS; c++) begin
                if (sample && (r_q == RW'(rr))) begin
                    cnt_new = cnt_q[rr*COLS + c];
                    if (col_q[c]) begin
                        if (cnt_new != CW'(DEBOUNCE)) cnt_new = cnt_new + CW'(1);
                    end else if (cnt_new != '0) begin
                        cnt_new = cnt_new - CW'(1);
                    end
                    cnt_d[rr*COLS + c] = cnt_new;
                    if ((cnt_new == CW'(DEBOUNCE)) && !keys_q[rr*COLS + c]) begin
                        keys_d[rr*COLS + c]      = 1'b1;
                        key_press_d[rr*COLS + c] = 1'b1;
                    end else if ((cnt_new == '0) && keys_q[rr*COLS + c]) begin
                        keys_d[rr*COLS + c]        = 1'b0;
                        key_release_d[rr*COLS + c] = 1'b1;
                    end
                end
            end
        end

        // Outputs are registered from next-state so they line up with r/t.
        row_drive_d = '0;
        if (state_d == ST_SCAN) row_drive_d[r_d] = 1'b1;
        scan_done_d = (state_d == ST_SCAN) && (t_d == TW'(SETTLE - 1)) &&
                      (r_d == RW'(ROWS - 1));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            r_q           <= '0;
            t_q           <= '0;
            row_drive_q   <= '0;
            scan_done_q   <= 1'b0;
            sync1_q       <= '1;
            sync2_q       <= '1;
            col_q         <= '0;
            cnt_q         <= '0;
            keys_q        <= '0;
            key_press_q   <= '0;
            key_release_q <= '0;
        end else begin
            state_q       <= state_d;
            r_q           <= r_d;
            t_q           <= t_d;
            row_drive_q   <= row_drive_d;
            scan_done_q   <= scan_done_d;
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            col_q         <= col_d;
            cnt_q         <= cnt_d;
            keys_q        <= keys_d;
            key_press_q   <= key_press_d;
            key_release_q <= key_release_d;
        end
    end

    assign row_drive   = row_drive_q;
    assign keys        = keys_q;
    assign key_press   = key_press_q;
    assign key_release = key_release_q;
    assign scan_done   = scan_done_q;

endmodule

// File: tb/tb_front_panel_scanner.sv
// Directed bench for front_panel_scanner: ROWS=4, COLS=8, SETTLE=8, DEBOUNCE=3.
module tb_front_panel_scanner;

    localparam int ROWS = 4;
    localparam int COLS = 8;
    localparam int NK   = ROWS * COLS;

    localparam int M_PRESS  = 0;
    localparam int M_BOUNCE = 1;
    localparam int M_STUCK  = 2;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [COLS-1:0] col_n;
    logic [ROWS-1:0] row_drive;
    logic [NK-1:0]   keys, key_press, key_release;
    logic            scan_done;

    int cyc = -1;
    int mode = M_PRESS;
    int n_checks = 0;
    int n_fail = 0;
    logic bounce_press_seen = 1'b0;

    front_panel_scanner #(
        .ROWS(ROWS), .COLS(COLS), .SETTLE(8), .DEBOUNCE(3)
    ) dut (
        .clk(clk), .reset(reset), .col_n(col_n), .row_drive(row_drive),
        .keys(keys), .key_press(key_press), .key_release(key_release),
        .scan_done(scan_done)
    );

    always #5 clk = ~clk;

    // Cycle 0 is the period after the first edge that samples reset low.
    always @(posedge clk) cyc <= reset ? -1 : cyc + 1;

    always_comb begin
        col_n = '1;
        case (mode)
            M_PRESS:  if (row_drive[1] && cyc < 100) col_n[5] = 1'b0;
            M_BOUNCE: if (row_drive[1] && (cyc < 48 || (cyc >= 96 && cyc < 144)))
                          col_n[5] = 1'b0;
            M_STUCK:  col_n[0] = 1'b0;
            default:  col_n = '1;
        endcase
    end

    always @(negedge clk)
        if (mode == M_BOUNCE && cyc >= 0 && cyc <= 143 && key_press[13])
            bounce_press_seen = 1'b1;

    task automatic check_eq(input string tag, input logic [63:0] got,
                            input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic at_cyc(input int n);
        int guard;
        guard = 0;
        @(negedge clk);
        while (cyc != n && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (cyc != n) check_eq("cycle_wait", 64'(cyc), 64'(n));
    endtask

    task automatic do_reset(input int m);
        @(negedge clk);
        reset = 1'b1;
        mode = m;
        repeat (3) @(negedge clk);
        check_eq("rst_row_drive", 64'(row_drive), 64'h0);
        check_eq("rst_keys", 64'(keys), 64'h0);
        check_eq("rst_scan_done", 64'(scan_done), 64'h0);
        reset = 1'b0;
    endtask

    initial begin
        // Rotation, press and release
        do_reset(M_PRESS);
        at_cyc(0);   check_eq("row_c0", 64'(row_drive), 64'b0001);
        at_cyc(8);   check_eq("row_c8", 64'(row_drive), 64'b0010);
        at_cyc(16);  check_eq("row_c16", 64'(row_drive), 64'b0100);
        at_cyc(24);  check_eq("row_c24", 64'(row_drive), 64'b1000);
        at_cyc(30);  check_eq("done_c30", 64'(scan_done), 64'h0);
        at_cyc(31);  check_eq("done_c31", 64'(scan_done), 64'h1);
        at_cyc(32);  check_eq("row_c32", 64'(row_drive), 64'b0001);
                     check_eq("done_c32", 64'(scan_done), 64'h0);
        at_cyc(63);  check_eq("done_c63", 64'(scan_done), 64'h1);
        at_cyc(79);  check_eq("keys_c79", 64'(keys), 64'h0);
        at_cyc(80);  check_eq("keys_c80", 64'(keys), 64'h0000_2000);
                     check_eq("press_c80", 64'(key_press), 64'h0000_2000);
        at_cyc(81);  check_eq("press_c81", 64'(key_press), 64'h0);
        at_cyc(175); check_eq("keys_c175", 64'(keys), 64'h0000_2000);
                     check_eq("rel_c175", 64'(key_release), 64'h0);
        at_cyc(176); check_eq("keys_c176", 64'(keys), 64'h0);
                     check_eq("rel_c176", 64'(key_release), 64'h0000_2000);
        at_cyc(177); check_eq("rel_c177", 64'(key_release), 64'h0);

        // Bounce: closed at samples 15,47, open at 79, closed at 111,143
        do_reset(M_BOUNCE);
        bounce_press_seen = 1'b0;
        at_cyc(143); check_eq("bounce_keys_c143", 64'(keys), 64'h0);
                     check_eq("bounce_press_seen", 64'(bounce_press_seen), 64'h0);
        at_cyc(144); check_eq("bounce_keys_c144", 64'(keys), 64'h0000_2000);

        // Reset mid-operation while key 13 is held
        do_reset(M_PRESS);
        at_cyc(90);  check_eq("mid_keys_c90", 64'(keys), 64'h0000_2000);
        reset = 1'b1;
        @(negedge clk);
        check_eq("mid_rst_keys", 64'(keys), 64'h0);
        check_eq("mid_rst_row", 64'(row_drive), 64'h0);
        check_eq("mid_rst_release", 64'(key_release), 64'h0);
        reset = 1'b0;
        at_cyc(0);   check_eq("mid_row_c0", 64'(row_drive), 64'b0001);
        at_cyc(8);   check_eq("mid_row_c8", 64'(row_drive), 64'b0010);
        at_cyc(79);  check_eq("mid_keys_c79", 64'(keys), 64'h0);
        at_cyc(80);  check_eq("mid_keys_c80", 64'(keys), 64'h0000_2000);

        // Column 0 stuck low on every row
        do_reset(M_STUCK);
        at_cyc(71);  check_eq("stuck_c71", 64'(keys), 64'h0);
        at_cyc(72);  check_eq("stuck_c72", 64'(keys), 64'h0000_0001);
        at_cyc(79);  check_eq("stuck_c79", 64'(keys), 64'h0000_0001);
        at_cyc(80);  check_eq("stuck_c80", 64'(keys), 64'h0000_0101);
        at_cyc(88);  check_eq("stuck_c88", 64'(keys), 64'h0001_0101);
        at_cyc(96);  check_eq("stuck_c96", 64'(keys), 64'h0101_0101);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
